// File: rtl/out_port_fifo.sv
// Output port FIFO: captures bus words on out_in and hands them to a device via valid/ack.
// Define OUTPORT_OVERFLOW_EN to enable the sticky overflow flag on dropped writes.
module out_port_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                       Clock,
    input  logic                       clear,
    input  logic [DW-1:0]              bus_data,
    input  logic                       out_in,
    output logic [DW-1:0]              dev_data,
    output logic                       dev_valid,
    input  logic                       dev_ack,
    output logic [DW-1:0]              out_value,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_nxt;

    // A pop frees a slot at this edge, so a write at full can still land.
    assign pop  = dev_ack && !empty;
    assign push = out_in && (!full || pop);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (!clear && push)
            mem[wr_ptr] <= bus_data;
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            out_value <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                out_value <= bus_data;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

`ifdef OUTPORT_OVERFLOW_EN
    always_ff @(posedge Clock) begin
        if (clear)
            overflow <= 1'b0;
        else if (out_in && full && !pop)
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

    assign dev_valid = !empty;
    assign dev_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_out_port_fifo.sv
// Directed table-driven bench for out_port_fifo (DEPTH=4, DW=32).
// Overflow expectations follow OUTPORT_OVERFLOW_EN when it is defined.
module tb_out_port_fifo;
    localparam int DW = 32;
`ifdef OUTPORT_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          clear;
    logic [DW-1:0] bus_data;
    logic          out_in;
    logic [DW-1:0] dev_data;
    logic          dev_valid;
    logic          dev_ack;
    logic [DW-1:0] out_value;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;

    int compared = 0;
    int mismatched = 0;

    out_port_fifo #(.DEPTH(4), .DW(DW)) dut (
        .Clock(Clock),
        .clear(clear),
        .bus_data(bus_data),
        .out_in(out_in),
        .dev_data(dev_data),
        .dev_valid(dev_valid),
        .dev_ack(dev_ack),
        .out_value(out_value),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow(overflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        clr;
        logic        oin;
        logic        ack;
        logic [31:0] data;
        logic [2:0]  cnt;
        logic        val;
        logic [31:0] dd;
        logic [31:0] ov;
        logic        fl;
        logic        em;
        logic        ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic c, input logic oi, input logic a,
                        input logic [31:0] d);
        @(negedge Clock);
        clear    = c;
        out_in   = oi;
        dev_ack  = a;
        bus_data = d;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] c,
                             input logic [31:0] head, input logic [31:0] ov);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".dev_valid"}, 32'(dev_valid), 32'(c != 0));
        chk({tag, ".dev_data"}, dev_data, head);
        chk({tag, ".out_value"}, out_value, ov);
        chk({tag, ".full"}, 32'(full), 32'(c == 4));
        chk({tag, ".empty"}, 32'(empty), 32'(c == 0));
    endtask

    initial begin
        clear = 1'b1;
        out_in = 1'b0;
        dev_ack = 1'b0;
        bus_data = '0;

        //           clr  oin  ack  data         cnt  val  dd     ov     fl   em   ovf
        vecs[0]  = '{1'b1,1'b1,1'b0,32'hDEADBEEF,3'd0,1'b0,32'h0, 32'h0, 1'b0,1'b1,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,32'hDEADBEEF,3'd0,1'b0,32'h0, 32'h0, 1'b0,1'b1,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,       3'd0,1'b0,32'h0, 32'h0, 1'b0,1'b1,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,32'h55,      3'd1,1'b1,32'h55,32'h55,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b1,32'h0,       3'd0,1'b0,32'h0, 32'h55,1'b0,1'b1,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,32'h1,       3'd1,1'b1,32'h1, 32'h1, 1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b0,32'h2,       3'd2,1'b1,32'h1, 32'h2, 1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,32'h3,       3'd3,1'b1,32'h1, 32'h3, 1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b1,1'b0,32'h4,       3'd4,1'b1,32'h1, 32'h4, 1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b0,32'h5,       3'd4,1'b1,32'h1, 32'h4, 1'b1,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b0,1'b1,32'h0,       3'd3,1'b1,32'h2, 32'h4, 1'b0,1'b0,1'b1};
        vecs[11] = '{1'b0,1'b0,1'b1,32'h0,       3'd2,1'b1,32'h3, 32'h4, 1'b0,1'b0,1'b1};
        vecs[12] = '{1'b0,1'b0,1'b1,32'h0,       3'd1,1'b1,32'h4, 32'h4, 1'b0,1'b0,1'b1};
        vecs[13] = '{1'b0,1'b0,1'b1,32'h0,       3'd0,1'b0,32'h0, 32'h4, 1'b0,1'b1,1'b1};

        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].clr, vecs[i].oin, vecs[i].ack, vecs[i].data);
            chk({tag, ".count"}, 32'(count), 32'(vecs[i].cnt));
            chk({tag, ".dev_valid"}, 32'(dev_valid), 32'(vecs[i].val));
            chk({tag, ".dev_data"}, dev_data, vecs[i].dd);
            chk({tag, ".out_value"}, out_value, vecs[i].ov);
            chk({tag, ".full"}, 32'(full), 32'(vecs[i].fl));
            chk({tag, ".empty"}, 32'(empty), 32'(vecs[i].em));
            chk({tag, ".overflow"}, 32'(overflow), 32'(vecs[i].ovf & OVF_EN));
        end

        // Overflow stays set across pushes and pops until clear.
        step(1'b0, 1'b1, 1'b0, 32'h9);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("sticky.overflow", 32'(overflow), 32'(OVF_EN));
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("clr.overflow", 32'(overflow), 32'h0);
        chk_state("clr", 3'd0, 32'h0, 32'h0);

        // Push and pop together at full: new word lands in the vacated slot.
        step(1'b0, 1'b1, 1'b0, 32'hA);
        step(1'b0, 1'b1, 1'b0, 32'hB);
        step(1'b0, 1'b1, 1'b0, 32'hC);
        step(1'b0, 1'b1, 1'b0, 32'hD);
        chk_state("simfull.pre", 3'd4, 32'hA, 32'hD);
        step(1'b0, 1'b1, 1'b1, 32'hE);
        chk_state("simfull.post", 3'd4, 32'hB, 32'hE);
        chk("simfull.overflow", 32'(overflow), 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk_state("drain1", 3'd3, 32'hC, 32'hE);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk_state("drain2", 3'd2, 32'hD, 32'hE);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk_state("drain3", 3'd1, 32'hE, 32'hE);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk_state("drain4", 3'd0, 32'h0, 32'hE);

        // Ack while empty is ignored; then push with ack on empty pushes only.
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk_state("ackempty", 3'd0, 32'h0, 32'hE);
        step(1'b0, 1'b1, 1'b1, 32'h66);
        chk_state("pushack.empty", 3'd1, 32'h66, 32'h66);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk_state("pushack.pop", 3'd0, 32'h0, 32'h66);

        // One-at-a-time traffic across several pointer wraps.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] w;
            w = 32'h100 + 32'(i * 17);
            step(1'b0, 1'b1, 1'b0, w);
            chk_state($sformatf("wrap%0d.push", i), 3'd1, w, w);
            step(1'b0, 1'b0, 1'b1, 32'h0);
            chk_state($sformatf("wrap%0d.pop", i), 3'd0, 32'h0, w);
        end

        // Reset in the middle of traffic overrides push and ack.
        step(1'b0, 1'b1, 1'b0, 32'h21);
        step(1'b0, 1'b1, 1'b0, 32'h22);
        step(1'b0, 1'b1, 1'b0, 32'h23);
        chk_state("mid.pre", 3'd3, 32'h21, 32'h23);
        step(1'b1, 1'b1, 1'b1, 32'h99);
        chk_state("mid.clr", 3'd0, 32'h0, 32'h0);
        chk("mid.overflow", 32'(overflow), 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h77);
        chk_state("mid.push", 3'd1, 32'h77, 32'h77);

        step(1'b0, 1'b0, 1'b0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
